// File: rtl/mul_unit_arbiter.sv
// rtl/mul_unit_arbiter.sv - round-robin sharing of one Booth multiplier between INT (RV32M) and FP mantissa paths
module mul_unit_arbiter #(
   parameter int XLEN   = 32,
   parameter int MANT_W = 24
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  int_req_valid_i,
   output logic                  int_req_ready_o,
   input  logic [1:0]            int_op_i,
   input  logic [XLEN-1:0]       int_a_i,
   input  logic [XLEN-1:0]       int_b_i,
   input  logic                  int_kill_i,
   output logic                  int_rsp_valid_o,
   input  logic                  int_rsp_ready_i,
   output logic [XLEN-1:0]       int_rsp_o,
   input  logic                  fp_req_valid_i,
   output logic                  fp_req_ready_o,
   input  logic [MANT_W-1:0]     fp_a_i,
   input  logic [MANT_W-1:0]     fp_b_i,
   output logic                  fp_rsp_valid_o,
   input  logic                  fp_rsp_ready_i,
   output logic [2*MANT_W-1:0]   fp_rsp_o,
   output logic                  mul_start_o,
   output logic [XLEN-1:0]       mul_a_o,
   output logic [XLEN-1:0]       mul_b_o,
   input  logic                  mul_valid_i,
   input  logic [2*XLEN-1:0]     mul_result_i
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

   localparam logic SRC_INT = 1'b0;
   localparam logic SRC_FP  = 1'b1;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  src_q, src_d;
   logic [1:0]            op_q, op_d;
   logic [XLEN-1:0]       a_q, a_d;
   logic [XLEN-1:0]       b_q, b_d;
   logic                  killed_q, killed_d;
   logic [XLEN-1:0]       int_rsp_q, int_rsp_d;
   logic [2*MANT_W-1:0]   fp_rsp_q, fp_rsp_d;
   logic                  int_rsp_valid_q, int_rsp_valid_d;
   logic                  fp_rsp_valid_q, fp_rsp_valid_d;

   logic                  grant_int, grant_fp;
   logic                  kill_now;
   logic [XLEN-1:0]       p_hi;
   logic [XLEN-1:0]       int_result;

   assign p_hi = mul_result_i[2*XLEN-1:XLEN];

   // Round-robin grant; a request being killed in the same cycle is not a candidate
   always_comb begin
      grant_int = int_req_valid_i && !int_kill_i && (!fp_req_valid_i || (last_grant_q == SRC_FP));
      grant_fp  = fp_req_valid_i && !grant_int;
   end

   // Signed product corrected into the RV32M result selected by the latched op
   always_comb begin
      int_result = p_hi;
      case (op_q)
         OP_MUL:    int_result = mul_result_i[XLEN-1:0];
         OP_MULH:   int_result = p_hi;
         OP_MULHSU: int_result = p_hi + (b_q[XLEN-1] ? a_q : '0);
         default:   int_result = p_hi + (a_q[XLEN-1] ? b_q : '0) + (b_q[XLEN-1] ? a_q : '0);
      endcase
   end

   // Next-state, latched operands and registered responses
   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      src_d           = src_q;
      op_d            = op_q;
      a_d             = a_q;
      b_d             = b_q;
      killed_d        = killed_q;
      int_rsp_d       = int_rsp_q;
      fp_rsp_d        = fp_rsp_q;
      int_rsp_valid_d = int_rsp_valid_q;
      fp_rsp_valid_d  = fp_rsp_valid_q;
      int_req_ready_o = 1'b0;
      fp_req_ready_o  = 1'b0;
      kill_now        = (src_q == SRC_INT) && (killed_q || int_kill_i);

      case (state_q)
         S_IDLE: begin
            int_req_ready_o = grant_int;
            fp_req_ready_o  = grant_fp;
            if (grant_int) begin
               src_d        = SRC_INT;
               op_d         = int_op_i;
               a_d          = int_a_i;
               b_d          = int_b_i;
               last_grant_d = SRC_INT;
               killed_d     = 1'b0;
               state_d      = S_ISSUE;
            end else if (grant_fp) begin
               src_d        = SRC_FP;
               op_d         = OP_MUL;
               a_d          = {{(XLEN-MANT_W){1'b0}}, fp_a_i};
               b_d          = {{(XLEN-MANT_W){1'b0}}, fp_b_i};
               last_grant_d = SRC_FP;
               killed_d     = 1'b0;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            killed_d = kill_now;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (mul_valid_i) begin
               killed_d = 1'b0;
               if (kill_now) begin
                  // The multiplier cannot be aborted, so a killed op just drains here
                  state_d = S_IDLE;
               end else begin
                  if (src_q == SRC_INT) begin
                     int_rsp_d       = int_result;
                     int_rsp_valid_d = 1'b1;
                  end else begin
                     fp_rsp_d        = mul_result_i[2*MANT_W-1:0];
                     fp_rsp_valid_d  = 1'b1;
                  end
                  state_d = S_RESPOND;
               end
            end else begin
               killed_d = kill_now;
            end
         end
         default: begin
            if (src_q == SRC_INT) begin
               if (int_kill_i || int_rsp_ready_i) begin
                  int_rsp_valid_d = 1'b0;
                  state_d         = S_IDLE;
               end
            end else if (fp_rsp_ready_i) begin
               fp_rsp_valid_d = 1'b0;
               state_d        = S_IDLE;
            end
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= S_IDLE;
         last_grant_q    <= SRC_FP;
         src_q           <= SRC_INT;
         op_q            <= OP_MUL;
         a_q             <= '0;
         b_q             <= '0;
         killed_q        <= 1'b0;
         int_rsp_q       <= '0;
         fp_rsp_q        <= '0;
         int_rsp_valid_q <= 1'b0;
         fp_rsp_valid_q  <= 1'b0;
      end else begin
         state_q         <= state_d;
         last_grant_q    <= last_grant_d;
         src_q           <= src_d;
         op_q            <= op_d;
         a_q             <= a_d;
         b_q             <= b_d;
         killed_q        <= killed_d;
         int_rsp_q       <= int_rsp_d;
         fp_rsp_q        <= fp_rsp_d;
         int_rsp_valid_q <= int_rsp_valid_d;
         fp_rsp_valid_q  <= fp_rsp_valid_d;
      end
   end

   assign mul_start_o     = (state_q == S_ISSUE);
   assign mul_a_o         = a_q;
   assign mul_b_o         = b_q;
   assign int_rsp_valid_o = int_rsp_valid_q;
   assign int_rsp_o       = int_rsp_q;
   assign fp_rsp_valid_o  = fp_rsp_valid_q;
   assign fp_rsp_o        = fp_rsp_q;

endmodule
